// File: rtl/adcs747x_frame_overlap.sv
// adcs747x_frame_overlap
// Regroups a 16-bit ADC sample stream into overlapping FRAME_LEN-sample
// AXI-Stream packets. Consecutive frames start HOP samples apart. Samples
// sit in a 2*FRAME_LEN circular buffer until every frame that uses them
// has been emitted. The capture stage cannot be stalled, so a sample that
// arrives while the buffer is full is dropped and a sticky OVERFLOW flag
// is raised.
module adcs747x_frame_overlap #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 256,
  parameter int HOP        = 128
) (
  input  logic                  AXIS_ACLK,
  input  logic                  AXIS_ARESET,
  input  logic                  S_AXIS_TVALID,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  output logic                  S_AXIS_TREADY,
  output logic                  M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic                  OVERFLOW
);
  // Capacity is FRAME_LEN + HOP rounded up to a power of two. The overlap
  // region therefore cannot be overwritten before it is released.
  localparam int DEPTH = 2 * FRAME_LEN;
  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = $clog2(FRAME_LEN);
  localparam int FW    = AW + 1;

  localparam logic [FW-1:0] C_DEPTH = FW'(DEPTH);
  localparam logic [FW-1:0] C_FLEN  = FW'(FRAME_LEN);
  localparam logic [FW-1:0] C_HOP   = FW'(HOP);
  localparam logic [AW-1:0] C_HOP_A = AW'(HOP);
  localparam logic [IW-1:0] C_LAST  = IW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT} state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_base_ptr;
  logic [FW-1:0]         r_fill;
  logic [IW-1:0]         r_rd_idx;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_overflow;

  logic                  w_s_ready;
  logic                  w_wr_en;
  logic                  w_hs;
  logic                  w_release;
  logic [FW-1:0]         w_fill_next;
  logic [IW-1:0]         w_idx_nxt;
  logic [IW-1:0]         w_rd_sel;
  logic [AW-1:0]         w_rd_addr;

  // Ready is derived from the registered fill. A write in the release
  // cycle of a full buffer is therefore still rejected.
  assign w_s_ready   = (r_fill != C_DEPTH);
  assign w_wr_en     = S_AXIS_TVALID && w_s_ready;
  assign w_hs        = r_tvalid && M_AXIS_TREADY;
  assign w_release   = (r_state == S_EMIT) && w_hs && (r_rd_idx == C_LAST);
  assign w_fill_next = r_fill + {{(FW-1){1'b0}}, w_wr_en} - (w_release ? C_HOP : '0);

  // LOAD fetches the beat at rd_idx. EMIT prefetches the following beat on
  // a handshake.
  assign w_idx_nxt = r_rd_idx + IW'(1);
  assign w_rd_sel  = (r_state == S_LOAD) ? r_rd_idx : w_idx_nxt;
  assign w_rd_addr = r_base_ptr + {{(AW-IW){1'b0}}, w_rd_sel};

  assign S_AXIS_TREADY = w_s_ready;
  assign M_AXIS_TVALID = r_tvalid;
  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TLAST  = r_tlast;
  assign OVERFLOW      = r_overflow;

  // Sample buffer. It has no reset, because stale contents are never read
  // once the pointers restart.
  always_ff @(posedge AXIS_ACLK) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= S_AXIS_TDATA;
  end

  // FSM state register.
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  // Next-state logic: wait for a full frame, load, emit, then chain or idle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (r_fill >= C_FLEN) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_EMIT;
      S_EMIT: if (w_release) w_state_nxt = (w_fill_next >= C_FLEN) ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pointers, fill, overflow flag and the registered output beat.
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      r_wr_ptr   <= '0;
      r_base_ptr <= '0;
      r_fill     <= '0;
      r_rd_idx   <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_tdata    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_fill <= w_fill_next;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (S_AXIS_TVALID && !w_s_ready) r_overflow <= 1'b1;
      case (r_state)
        S_LOAD: begin
          r_tvalid <= 1'b1;
          r_tdata  <= r_mem[w_rd_addr];
          r_tlast  <= (r_rd_idx == C_LAST);
        end
        S_EMIT: begin
          if (w_hs) begin
            if (r_rd_idx == C_LAST) begin
              r_tvalid   <= 1'b0;
              r_tlast    <= 1'b0;
              r_rd_idx   <= '0;
              r_base_ptr <= r_base_ptr + C_HOP_A;
            end else begin
              r_rd_idx <= w_idx_nxt;
              r_tdata  <= r_mem[w_rd_addr];
              r_tlast  <= (w_idx_nxt == C_LAST);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/adcs747x_frame_overlap.md
# adcs747x_frame_overlap

Takes the 16-bit sample stream produced by the ADCS747x SPI-to-AXI-Stream capture stage and regroups it into fixed-length, overlapping analysis frames for the downstream spectral front end (window/FFT). Samples go into a circular buffer. Each frame of FRAME_LEN samples is emitted as one AXI-Stream packet with TLAST on its final beat, and consecutive frames start HOP samples apart. Input-side overflow is detected and latched because the capture stage does not honour backpressure.

## Interface
Parameters:
- DATA_WIDTH, 16: sample width.
- FRAME_LEN, 256: samples per output frame; power of 2, ≥ 4.
- HOP, 128: frame-to-frame advance; 1 ≤ HOP ≤ FRAME_LEN.
- DEPTH (derived, 2*FRAME_LEN): buffer capacity in samples; not overridable.

Ports:
- AXIS_ACLK  in  1  sole clock.
- AXIS_ARESET  in  1  asynchronous, active-high reset.
- S_AXIS_TVALID  in  1  input sample valid (single-cycle pulses from capture stage).
- S_AXIS_TDATA  in  DATA_WIDTH  input sample.
- S_AXIS_TREADY  out  1  buffer not full.
- M_AXIS_TVALID  out  1  output beat valid.
- M_AXIS_TDATA  out  DATA_WIDTH  output sample, registered.
- M_AXIS_TLAST  out  1  last beat of frame.
- M_AXIS_TREADY  in  1  downstream ready.
- OVERFLOW  out  1  sticky; a sample arrived while full.

## Operation
- Write side: on S_AXIS_TVALID && S_AXIS_TREADY, store at wr_ptr, wr_ptr++ (mod DEPTH). Input TLAST/TSTRB are not used.
- S_AXIS_TREADY = (fill != DEPTH).
- Overflow: S_AXIS_TVALID && !S_AXIS_TREADY drops the sample and sets OVERFLOW. OVERFLOW clears only on reset.
- fill counts samples held, width clog2(DEPTH)+1. Each cycle: fill_next = fill + write − (release ? HOP : 0). A write and a release in the same cycle are both applied.
- FSM states:
  - IDLE: wait for fill ≥ FRAME_LEN. Then rd_idx=0, issue a buffer read at base_ptr, go to LOAD.
  - LOAD: read data lands in the output register. Assert M_AXIS_TVALID, go to EMIT.
  - EMIT: on each handshake, present the next sample (base_ptr+rd_idx). When the handshake is on the beat with rd_idx==FRAME_LEN−1, release: base_ptr += HOP (mod DEPTH), fill −= HOP. Then:
    - if fill_next ≥ FRAME_LEN, go straight to LOAD for the next frame;
    - else go to IDLE.
- M_AXIS_TLAST = M_AXIS_TVALID && (rd_idx of presented beat == FRAME_LEN−1).
- Frame k contains input samples k*HOP … k*HOP+FRAME_LEN−1, counted from reset and excluding dropped samples.
- Samples in the overlap region are never overwritten before release, because DEPTH ≥ FRAME_LEN + HOP.

## Timing
- Reset (async assert, sync release): M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, OVERFLOW=0, S_AXIS_TREADY=1, fill=0, pointers=0, FSM=IDLE.
- First-beat latency: the write that brings fill to FRAME_LEN is at edge N. IDLE sees the threshold at N+1, LOAD runs at N+1→N+2, and M_AXIS_TVALID is high after edge N+2.
- Throughput: with M_AXIS_TREADY held high, one beat per cycle, gapless within a frame.
- Between back-to-back frames there is exactly one LOAD cycle with TVALID=0.
- Backpressure: while M_AXIS_TVALID && !M_AXIS_TREADY, TDATA and TLAST hold stable and TVALID stays high. Stall length is unbounded and writes continue.
- Deasserting M_AXIS_TREADY mid-frame loses or repeats no beat. The read address advances only on a handshake, prefetching the next sample as needed.
- Full and emitting: TREADY=0 until the release cycle. The write arriving in the release cycle itself is still rejected, because TREADY reflects the registered fill.
- Reset mid-frame: the frame is abandoned and TVALID drops asynchronously. After release, the first frame is built from fresh samples only.

## Test plan
- FRAME_LEN=8, HOP=4; write samples 0..15, M_AXIS_TREADY=1. Required:
  - frame A = 0..7 with TLAST on 7;
  - frame B = 4..11;
  - frame C = 8..15;
  - TVALID first high 2 cycles after sample 7 is written;
  - one idle cycle between A and B.
- FRAME_LEN=8, HOP=8; write 0..23. Required: three frames 0–7, 8–15, 16–23 with no repeated samples.
- FRAME_LEN=8, HOP=4; write 0..11, then toggle M_AXIS_TREADY 1,0,0,1 repeatedly. Required: frame A = 0..7, with TDATA stable during stalls and no beat lost or duplicated.
- FRAME_LEN=8, HOP=4, M_AXIS_TREADY=0; write 20 samples. Required:
  - S_AXIS_TREADY drops after the 16th sample;
  - samples 17–20 are dropped and OVERFLOW=1;
  - after releasing TREADY, frames are 0..7, 4..11, 8..15;
  - OVERFLOW stays 1.
- Assert AXIS_ARESET on the 3rd beat of frame A. Required:
  - TVALID=0 and OVERFLOW=0 immediately;
  - after release, writing 100..107 yields a frame of exactly 100..107.
